// File: rtl/sump_pkg.sv
// ---------------------------------------------------------------------------
// sump_pkg
// Shared SUMP protocol definitions used by the command decoder and by the
// metadata / transmit blocks.
//   - Short opcode constants (single-byte commands, bit 7 clear)
//   - Index of the bit that marks a long (five-byte) command
//   - Decoder state encoding
// ---------------------------------------------------------------------------
package sump_pkg;

   localparam logic [7:0] SUMP_RESET      = 8'h00;
   localparam logic [7:0] SUMP_RUN        = 8'h01;
   localparam logic [7:0] SUMP_ID         = 8'h02;
   localparam logic [7:0] SUMP_QUERY_META = 8'h04;
   localparam logic [7:0] SUMP_XON        = 8'h11;
   localparam logic [7:0] SUMP_XOFF       = 8'h13;

   // Opcodes with this bit set carry four data bytes, LSB first.
   localparam int SUMP_LONG_BIT = 7;

   typedef enum logic [0:0] {
      DEC_IDLE = 1'b0,   // waiting for an opcode byte
      DEC_LONG = 1'b1    // collecting the four data bytes of a long command
   } dec_state_e;

   function automatic logic is_long_op(input logic [7:0] b);
      return b[SUMP_LONG_BIT];
   endfunction

endpackage

// File: rtl/sump_cmd_decoder_if.sv
// ---------------------------------------------------------------------------
// sump_cmd_decoder_if
// Bundle between the byte receiver and the command decoder.
//   rx_valid/rx_data       : received byte strobe and value (receiver -> decoder)
//   execute/opcode/cmd_data: completed command (decoder -> consumers)
//   cmd_* / query_metadata : decoded short-command strobes
//   timeout_abort          : partial long command discarded
// master: drives the received bytes; slave: the decoder.
// ---------------------------------------------------------------------------
interface sump_cmd_decoder_if;

   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        execute;
   logic [7:0]  opcode;
   logic [31:0] cmd_data;
   logic        cmd_reset;
   logic        cmd_run;
   logic        cmd_id;
   logic        query_metadata;
   logic        cmd_xon;
   logic        cmd_xoff;
   logic        timeout_abort;

   modport master (
      output rx_valid, rx_data,
      input  execute, opcode, cmd_data, cmd_reset, cmd_run, cmd_id,
             query_metadata, cmd_xon, cmd_xoff, timeout_abort
   );

   modport slave (
      input  rx_valid, rx_data,
      output execute, opcode, cmd_data, cmd_reset, cmd_run, cmd_id,
             query_metadata, cmd_xon, cmd_xoff, timeout_abort
   );

endinterface

// File: rtl/sump_cmd_decoder_byte_timeout.sv
// ---------------------------------------------------------------------------
// byte_timeout
// Inter-byte idle counter. Counts cycles in which enable_i is high and
// clear_i is low; saturates at TIMEOUT. expire_o is a combinational strobe
// asserted in the cycle whose increment makes the count reach TIMEOUT, so the
// owner can register it alongside its other outputs. clear_i has priority, so
// a byte arriving in that same cycle suppresses the expiry.
// Ports:
//   clock, extReset : clock and asynchronous active-high reset
//   clear_i         : restart counting from zero
//   enable_i        : count this cycle
//   expire_o        : count reaches TIMEOUT this cycle
// ---------------------------------------------------------------------------
module byte_timeout #(
   parameter int TIMEOUT = 100000
) (
   input  logic clock,
   input  logic extReset,
   input  logic clear_i,
   input  logic enable_i,
   output logic expire_o
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT    = CW'(TIMEOUT);
   localparam logic [CW-1:0] LIMIT_M1 = CW'(TIMEOUT - 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   always_comb begin
      count_d  = count_q;
      expire_o = 1'b0;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i && (count_q != LIMIT)) begin
         count_d  = count_q + 1'b1;
         expire_o = (count_q == LIMIT_M1);
      end
   end

   always_ff @(posedge clock or posedge extReset) begin
      if (extReset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/sump_cmd_decoder.sv
// ---------------------------------------------------------------------------
// sump_cmd_decoder
// Assembles SUMP commands from the received byte stream. Short commands are
// one byte (bit 7 clear); long commands are an opcode byte plus four data
// bytes, least-significant first. Every completed command pulses execute with
// opcode/cmd_data; known short opcodes also pulse their own strobe. A long
// command left idle for TIMEOUT cycles is dropped (timeout_abort).
// Ports:
//   clock, extReset : clock and asynchronous active-high reset
//   bus (slave)     : rx_valid/rx_data in; execute, opcode, cmd_data,
//                     decoded strobes and timeout_abort out (all registered)
// ---------------------------------------------------------------------------
module sump_cmd_decoder
   import sump_pkg::*;
#(
   parameter int TIMEOUT = 100000
) (
   input  logic              clock,
   input  logic              extReset,
   sump_cmd_decoder_if.slave bus
);

   dec_state_e  state_q;
   logic [1:0]  idx_q;
   logic [31:0] asm_q;
   logic [7:0]  pend_op_q;
   logic [7:0]  opcode_q;
   logic [31:0] cmd_data_q;
   logic        execute_q;
   logic        cmd_reset_q;
   logic        cmd_run_q;
   logic        cmd_id_q;
   logic        query_meta_q;
   logic        cmd_xon_q;
   logic        cmd_xoff_q;
   logic        abort_q;

   logic        tmo_expire;
   logic [31:0] asm_next;

   // Bytes shift in from the top, so after four bytes the first one sits in
   // bits 7:0.
   assign asm_next = {bus.rx_data, asm_q[31:8]};

   // The counter only runs while a long command is open; any byte restarts it.
   byte_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clock    (clock),
      .extReset (extReset),
      .clear_i  (bus.rx_valid || (state_q == DEC_IDLE)),
      .enable_i (state_q == DEC_LONG),
      .expire_o (tmo_expire)
   );

   always_ff @(posedge clock or posedge extReset) begin
      if (extReset) begin
         state_q      <= DEC_IDLE;
         idx_q        <= '0;
         asm_q        <= '0;
         pend_op_q    <= '0;
         opcode_q     <= '0;
         cmd_data_q   <= '0;
         execute_q    <= 1'b0;
         cmd_reset_q  <= 1'b0;
         cmd_run_q    <= 1'b0;
         cmd_id_q     <= 1'b0;
         query_meta_q <= 1'b0;
         cmd_xon_q    <= 1'b0;
         cmd_xoff_q   <= 1'b0;
         abort_q      <= 1'b0;
      end else begin
         // Strobes are single-cycle unless re-asserted below.
         execute_q    <= 1'b0;
         cmd_reset_q  <= 1'b0;
         cmd_run_q    <= 1'b0;
         cmd_id_q     <= 1'b0;
         query_meta_q <= 1'b0;
         cmd_xon_q    <= 1'b0;
         cmd_xoff_q   <= 1'b0;
         abort_q      <= 1'b0;

         case (state_q)
            DEC_IDLE: begin
               if (bus.rx_valid) begin
                  if (is_long_op(bus.rx_data)) begin
                     pend_op_q <= bus.rx_data;
                     idx_q     <= '0;
                     asm_q     <= '0;
                     state_q   <= DEC_LONG;
                  end else begin
                     opcode_q     <= bus.rx_data;
                     cmd_data_q   <= '0;
                     execute_q    <= 1'b1;
                     cmd_reset_q  <= (bus.rx_data == SUMP_RESET);
                     cmd_run_q    <= (bus.rx_data == SUMP_RUN);
                     cmd_id_q     <= (bus.rx_data == SUMP_ID);
                     query_meta_q <= (bus.rx_data == SUMP_QUERY_META);
                     cmd_xon_q    <= (bus.rx_data == SUMP_XON);
                     cmd_xoff_q   <= (bus.rx_data == SUMP_XOFF);
                  end
               end
            end

            DEC_LONG: begin
               // Every byte here is payload, whatever its value.
               if (bus.rx_valid) begin
                  asm_q <= asm_next;
                  idx_q <= idx_q + 2'd1;
                  if (idx_q == 2'd3) begin
                     opcode_q   <= pend_op_q;
                     cmd_data_q <= asm_next;
                     execute_q  <= 1'b1;
                     state_q    <= DEC_IDLE;
                  end
               end else if (tmo_expire) begin
                  abort_q <= 1'b1;
                  state_q <= DEC_IDLE;
               end
            end

            default: state_q <= DEC_IDLE;
         endcase
      end
   end

   assign bus.execute        = execute_q;
   assign bus.opcode         = opcode_q;
   assign bus.cmd_data       = cmd_data_q;
   assign bus.cmd_reset      = cmd_reset_q;
   assign bus.cmd_run        = cmd_run_q;
   assign bus.cmd_id         = cmd_id_q;
   assign bus.query_metadata = query_meta_q;
   assign bus.cmd_xon        = cmd_xon_q;
   assign bus.cmd_xoff       = cmd_xoff_q;
   assign bus.timeout_abort  = abort_q;

endmodule

// File: tb/tb_sump_cmd_decoder.sv
// ---------------------------------------------------------------------------
// tb_sump_cmd_decoder
// Scoreboard bench for sump_cmd_decoder with TIMEOUT = 16. Stimulus tasks
// push the expected strobe event (cycle, strobe vector, opcode, cmd_data)
// when they drive a byte; a monitor pops and compares whenever any strobe is
// seen, and flags events that never arrived.
// Strobe vector bit order: {abort, xoff, xon, query_meta, id, run, reset, execute}
// ---------------------------------------------------------------------------
module tb_sump_cmd_decoder;

   localparam int TMO = 16;

   typedef struct {
      int          cyc;
      logic [7:0]  strb;
      logic [7:0]  op;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   last_cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   logic [7:0]  model_op = 8'h00;
   logic [31:0] model_data = 32'h0;

   exp_t sb_q[$];

   sump_cmd_decoder_if dec_bus ();

   sump_cmd_decoder #(
      .TIMEOUT (TMO)
   ) dut (
      .clock    (clk),
      .extReset (rst),
      .bus      (dec_bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] obs_strobes();
      return {dec_bus.timeout_abort, dec_bus.cmd_xoff, dec_bus.cmd_xon,
              dec_bus.query_metadata, dec_bus.cmd_id, dec_bus.cmd_run,
              dec_bus.cmd_reset, dec_bus.execute};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic push_exp(input int c, input logic [7:0] s, input logic [7:0] op,
                           input logic [31:0] d);
      exp_t e;
      e.cyc = c; e.strb = s; e.op = op; e.data = d;
      sb_q.push_back(e);
   endtask

   // Present one byte for exactly one clock; leaves us 1 time unit past the edge.
   task automatic send_raw(input logic [7:0] b);
      dec_bus.rx_valid = 1'b1;
      dec_bus.rx_data  = b;
      last_cyc = cyc;
      @(posedge clk);
      #1;
      dec_bus.rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_short(input logic [7:0] b);
      logic [7:0] s;
      s = 8'h01;
      case (b)
         8'h00: s = s | 8'h02;
         8'h01: s = s | 8'h04;
         8'h02: s = s | 8'h08;
         8'h04: s = s | 8'h10;
         8'h11: s = s | 8'h20;
         8'h13: s = s | 8'h40;
         default: ;
      endcase
      push_exp(cyc + 1, s, b, 32'h0);
      model_op = b;
      model_data = 32'h0;
      $display("short cmd 0x%02h sent at cycle %0d", b, cyc);
      send_raw(b);
   endtask

   task automatic send_long(input logic [7:0] op, input logic [31:0] d);
      send_raw(op);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) begin
            push_exp(cyc + 1, 8'h01, op, d);
            model_op = op;
            model_data = d;
         end
         send_raw(d[8*i +: 8]);
      end
      $display("long cmd 0x%02h data 0x%08h done at cycle %0d", op, d, last_cyc);
   endtask

   // Monitor: compare every strobe event against the scoreboard.
   initial begin
      exp_t e;
      logic [7:0] s;
      forever begin
         @(posedge clk);
         #1;
         while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            chk("missed_event_cycle", 64'(cyc), 64'(sb_q[0].cyc));
            void'(sb_q.pop_front());
         end
         s = obs_strobes();
         if (s != 8'h00) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_strobes", 64'(s), 64'h0);
            end else begin
               e = sb_q.pop_front();
               chk("event_cycle", 64'(cyc), 64'(e.cyc));
               chk("strobes", 64'(s), 64'(e.strb));
               chk("opcode", 64'(dec_bus.opcode), 64'(e.op));
               chk("cmd_data", 64'(dec_bus.cmd_data), 64'(e.data));
            end
         end
      end
   end

   initial begin
      logic [31:0] d;
      dec_bus.rx_valid = 1'b0;
      dec_bus.rx_data  = 8'h00;
      idle(3);
      chk("reset_strobes", 64'(obs_strobes()), 64'h0);
      chk("reset_opcode", 64'(dec_bus.opcode), 64'h0);
      chk("reset_cmd_data", 64'(dec_bus.cmd_data), 64'h0);
      rst = 1'b0;
      idle(2);

      // Query metadata.
      send_short(8'h04);
      idle(2);

      // Long command, consecutive bytes.
      send_long(8'hC0, 32'h1234_5678);
      idle(2);

      // Long command with all-zero payload: not a reset.
      send_long(8'h81, 32'h0000_0000);
      idle(2);

      // Timeout: opcode + one data byte, then silence.
      send_raw(8'h82);
      send_raw(8'h11);
      push_exp(last_cyc + TMO + 1, 8'h80, model_op, model_data);
      chk("held_opcode_partial", 64'(dec_bus.opcode), 64'(model_op));
      chk("held_data_partial", 64'(dec_bus.cmd_data), 64'(model_data));
      $display("partial long 0x82 left idle from cycle %0d", last_cyc);
      idle(20);
      send_short(8'h01);
      idle(2);

      // Reset in the middle of a long command.
      send_raw(8'h83);
      send_raw(8'hAA);
      send_raw(8'hBB);
      rst = 1'b1;
      #1;
      chk("midreset_opcode", 64'(dec_bus.opcode), 64'h0);
      chk("midreset_cmd_data", 64'(dec_bus.cmd_data), 64'h0);
      model_op = 8'h00;
      model_data = 32'h0;
      $display("extReset asserted mid-command at cycle %0d", cyc);
      idle(2);
      rst = 1'b0;
      idle(1);
      send_short(8'h02);
      idle(2);

      // Unknown short then XON/XOFF back to back.
      send_short(8'h55);
      send_short(8'h11);
      send_short(8'h13);
      idle(2);

      // Long command immediately followed by a short one during execute.
      send_long(8'hFF, 32'hDEAD_BEEF);
      send_short(8'h00);
      idle(2);

      // Byte arriving exactly when the counter would expire is accepted.
      d = 32'hA5C3_7E10;
      send_raw(8'h84);
      send_raw(d[7:0]);
      idle(TMO - 1);
      send_raw(d[15:8]);
      send_raw(d[23:16]);
      push_exp(cyc + 1, 8'h01, 8'h84, d);
      model_op = 8'h84;
      model_data = d;
      send_raw(d[31:24]);
      $display("boundary long 0x84 data 0x%08h done at cycle %0d", d, last_cyc);

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 60 && sb_q.size() > 0; i++) idle(1);
      idle(3);
      chk("scoreboard_drained", 64'(sb_q.size()), 64'h0);
      chk("final_opcode", 64'(dec_bus.opcode), 64'(model_op));
      chk("final_cmd_data", 64'(dec_bus.cmd_data), 64'(model_data));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
